mem2uart: RTL and testbench

- Reader side of the LPC capture ringbuffer.
- The writer stores one 48-bit record per captured LPC frame at ram_addr = {slot, 3'h0}. The record layout is: addr[47:16], data[15:8], 4'h0[7:4], cyctype_dir[3:0].
- This block reads each unread slot, splits the record into bytes (MSB first) and feeds them to the UART transmitter with a ready/write handshake.
- It advances its read pointer after every record and raises a one-cycle pulse per record sent.

---
 rtl/mem2uart.sv | 112 +++++++++++
 tb/tb_mem2uart.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem2uart.sv
// Reader side of the LPC capture ringbuffer: fetches 48-bit records and streams them MSB-first to a UART.
// Optional build macro LPC_SYNC_MARKER_EN prefixes every record with the sync byte 8'hA5.
module mem2uart #(
  parameter int PTR_WIDTH    = 5,
  parameter int RECORD_BYTES = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [PTR_WIDTH-1:0] write_ptr,
  output logic [PTR_WIDTH+2:0] ram_addr,
  input  logic [47:0]          ram_data,
  input  logic                 uart_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_write,
  output logic [PTR_WIDTH-1:0] read_ptr,
  output logic                 empty,
  output logic                 frame_sent
);

  localparam logic [2:0] LAST_BYTE = 3'(RECORD_BYTES);
`ifdef LPC_SYNC_MARKER_EN
  localparam logic [7:0] SYNC_MARKER = 8'hA5;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    LATCH,
    SEND,
    GAP,
    DONE
`ifdef LPC_SYNC_MARKER_EN
    , HDR
`endif
  } state_t;

  state_t      state;
  logic [2:0]  byte_cnt;
  logic [47:0] shift;

  assign ram_addr = {read_ptr, 3'h0};
  assign empty    = (read_ptr == write_ptr);

  // NOTE: every register, including the 48-bit shift buffer, is cleared by reset so the
  // wire never sees stale record bytes after a mid-record reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      read_ptr   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      uart_data  <= 8'h00;
      uart_write <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the strobes default low so each is a single-cycle pulse.
      uart_write <= 1'b0;
      frame_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !empty) state <= RD_ADDR;
        end
        RD_ADDR: begin
          state <= LATCH;
        end
        LATCH: begin
          shift    <= ram_data;
          byte_cnt <= '0;
`ifdef LPC_SYNC_MARKER_EN
          state    <= HDR;
`else
          state    <= SEND;
`endif
        end
`ifdef LPC_SYNC_MARKER_EN
        HDR: begin
          if (uart_ready) begin
            uart_data  <= SYNC_MARKER;
            uart_write <= 1'b1;
            state      <= GAP;
          end
        end
`endif
        SEND: begin
          if (uart_ready) begin
            uart_data  <= shift[47:40];
            uart_write <= 1'b1;
            shift      <= {shift[39:0], 8'h00};
            byte_cnt   <= byte_cnt + 3'd1;
            state      <= GAP;
          end
        end
        GAP: begin
          // The transmitter needs a cycle to drop ready after a write, so ready is ignored here.
          if (byte_cnt == LAST_BYTE) begin
            frame_sent <= 1'b1;
            state      <= DONE;
          end else begin
            state <= SEND;
          end
        end
        DONE: begin
          read_ptr <= read_ptr + PTR_WIDTH'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem2uart.sv
// Directed self-checking bench for mem2uart: reset, single record, backpressure, enable drop, wrap, mid-record reset.
module tb_mem2uart;

`ifdef LPC_SYNC_MARKER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int REC_LEN = HDR + 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  write_ptr;
  logic [7:0]  ram_addr;
  logic [47:0] ram_data;
  logic        uart_ready;
  logic [7:0]  uart_data;
  logic        uart_write;
  logic [4:0]  read_ptr;
  logic        empty;
  logic        frame_sent;

  mem2uart dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .write_ptr  (write_ptr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .uart_ready (uart_ready),
    .uart_data  (uart_data),
    .uart_write (uart_write),
    .read_ptr   (read_ptr),
    .empty      (empty),
    .frame_sent (frame_sent)
  );

  always #5 clock = ~clock;

  logic [47:0] mem [0:31];
  always @(posedge clock) ram_data <= mem[ram_addr[7:3]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dbl   = 0;
  logic prev_uw = 1'b0;
  logic [7:0] byte_q [$];
  int         time_q [$];
  logic [7:0] frame_q [$];
  logic [7:0] exp_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      if (uart_write) begin
        byte_q.push_back(uart_data);
        time_q.push_back(cyc);
        if (prev_uw) dbl++;
      end
      if (frame_sent) frame_q.push_back(ram_addr);
      prev_uw = uart_write;
    end else begin
      prev_uw = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic add_record(input logic [47:0] rec);
    if (HDR == 1) exp_q.push_back(8'hA5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(rec[i*8 +: 8]);
  endtask

  task automatic wait_bytes(input string tag, input int target, input int budget);
    int n = 0;
    while (byte_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(byte_q.size() >= target), 64'd1);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frame_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(frame_q.size() >= target), 64'd1);
  endtask

  task automatic compare_bytes(input string tag, input int base);
    check({tag, "_count"}, 64'(byte_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < byte_q.size()) check({tag, "_byte"}, 64'(byte_q[base+i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    int bb;
    int fb;
    for (int i = 0; i < 32; i++) mem[i] = {16'hA000 + 16'(i), 16'h0FF0, 8'(i), 8'h0C};
    mem[0] = 48'hFEDC_0080_5A0B;
    mem[1] = 48'hFEDC_0080_5A0B;
    mem[2] = 48'hA1B2_C3D4_E5F6;
    mem[3] = 48'h0102_0304_0506;

    // Reset then idle
    reset = 1'b0; enable = 1'b1; write_ptr = 5'd0; uart_ready = 1'b1;
    repeat (3) tick();
    check("rst_uart_write", 64'(uart_write), 64'd0);
    check("rst_uart_data", 64'(uart_data), 64'h00);
    check("rst_frame_sent", 64'(frame_sent), 64'd0);
    reset = 1'b1;
    repeat (8) tick();
    check("idle_writes", 64'(byte_q.size()), 64'd0);
    check("idle_empty", 64'(empty), 64'd1);
    check("idle_read_ptr", 64'(read_ptr), 64'd0);
    check("idle_ram_addr", 64'(ram_addr), 64'h00);

    // Single record at ready-high: 2-cycle byte spacing, one frame pulse
    exp_q.delete(); add_record(mem[0]);
    bb = byte_q.size(); fb = frame_q.size();
    write_ptr = 5'd1;
    wait_frames("single_timeout", fb + 1, 100);
    repeat (3) tick();
    compare_bytes("single", bb);
    for (int i = 1; i < REC_LEN; i++)
      if (bb + i < time_q.size()) check("single_spacing", 64'(time_q[bb+i] - time_q[bb+i-1]), 64'd2);
    check("single_frames", 64'(frame_q.size() - fb), 64'd1);
    check("single_read_ptr", 64'(read_ptr), 64'd1);
    check("single_empty", 64'(empty), 64'd1);
    check("single_strobe_len", 64'(dbl), 64'd0);

    // Backpressure after the second byte on the wire
    exp_q.delete(); add_record(mem[1]);
    bb = byte_q.size(); fb = frame_q.size();
    write_ptr = 5'd2;
    wait_bytes("bp_timeout", bb + 2, 100);
    uart_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_data", 64'(uart_data), 64'(exp_q[1]));
    end
    check("bp_no_write", 64'(byte_q.size() - bb), 64'd2);
    uart_ready = 1'b1;
    tick();
    check("bp_resume_write", 64'(uart_write), 64'd1);
    check("bp_resume_data", 64'(uart_data), 64'(exp_q[2]));
    wait_frames("bp_frame_timeout", fb + 1, 100);
    repeat (3) tick();
    compare_bytes("bp", bb);
    check("bp_read_ptr", 64'(read_ptr), 64'd2);

    // enable drops after the third record byte; record still completes
    exp_q.delete(); add_record(mem[2]);
    bb = byte_q.size(); fb = frame_q.size();
    write_ptr = 5'd4;
    wait_bytes("en_timeout", bb + HDR + 3, 100);
    enable = 1'b0;
    wait_frames("en_frame_timeout", fb + 1, 100);
    repeat (10) tick();
    compare_bytes("en_drop", bb);
    check("en_read_ptr", 64'(read_ptr), 64'd3);
    check("en_empty", 64'(empty), 64'd0);
    enable = 1'b1;
    wait_frames("en_resume_timeout", fb + 2, 100);
    repeat (3) tick();
    check("en_resume_read_ptr", 64'(read_ptr), 64'd4);

    // Drain to slot 31, then wrap across 31 -> 0
    write_ptr = 5'd31;
    wait_frames("drain_timeout", frame_q.size() + 27, 2000);
    repeat (3) tick();
    check("drain_read_ptr", 64'(read_ptr), 64'd31);
    mem[31] = 48'h1357_9BDF_2468;
    exp_q.delete(); add_record(mem[31]); add_record(mem[0]);
    bb = byte_q.size(); fb = frame_q.size();
    write_ptr = 5'd1;
    wait_frames("wrap_timeout", fb + 2, 200);
    repeat (5) tick();
    compare_bytes("wrap", bb);
    check("wrap_frames", 64'(frame_q.size() - fb), 64'd2);
    if (frame_q.size() >= fb + 2) begin
      check("wrap_addr0", 64'(frame_q[fb]), 64'hF8);
      check("wrap_addr1", 64'(frame_q[fb+1]), 64'h00);
    end
    check("wrap_read_ptr", 64'(read_ptr), 64'd1);

    // Reset asserted while the fourth record byte is being strobed
    bb = byte_q.size();
    write_ptr = 5'd2;
    wait_bytes("mid_rst_timeout", bb + HDR + 4, 100);
    check("mid_rst_pre_write", 64'(uart_write), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_uart_write", 64'(uart_write), 64'd0);
    check("mid_rst_uart_data", 64'(uart_data), 64'h00);
    check("mid_rst_read_ptr", 64'(read_ptr), 64'd0);
    check("mid_rst_ram_addr", 64'(ram_addr), 64'h00);
    check("mid_rst_frame_sent", 64'(frame_sent), 64'd0);
    repeat (2) tick();
    write_ptr = 5'd0;
    reset = 1'b1;
    repeat (10) tick();
    check("post_rst_writes", 64'(byte_q.size() - bb), 64'(HDR + 4));
    check("post_rst_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
